// File: rtl/dc_blocking_filter_if.sv
// rtl/dc_blocking_filter_if.sv - sample-in / sample-out valid/ready bundle for dc_blocking_filter
interface dc_blocking_filter_if #(
  parameter int G_DWIDTH = 24
);
  logic signed [G_DWIDTH-1:0] din;
  logic                       din_valid;
  logic                       din_ready;
  logic signed [G_DWIDTH-1:0] dout;
  logic                       dout_valid;
  logic                       dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/dc_blocking_filter.sv
// rtl/dc_blocking_filter.sv - first-order DC-blocking high-pass filter with guard bits and saturation
module dc_blocking_filter #(
  parameter int G_DWIDTH     = 24,
  parameter int G_POLE_SHIFT = 10,
  parameter int G_FRAC_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 bypass,
  input  logic                 flush,
  dc_blocking_filter_if.slave  s
);

  localparam int W  = G_DWIDTH + G_FRAC_BITS;
  localparam int AW = W + 3;

  localparam logic signed [AW-1:0] ACC_MAX = {{4{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{4{1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  Y_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  Y_MIN   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    SM_INIT,
    SM_GET_INPUT,
    SM_COMPUTE,
    SM_SEND_OUTPUT
  } state_t;

  state_t                     state;
  logic signed [G_DWIDTH-1:0] din_q;
  logic signed [G_DWIDTH-1:0] dout_q;
  logic signed [W-1:0]        x1;
  logic signed [W-1:0]        y1;
  logic signed [W-1:0]        x_ext;
  logic signed [W-1:0]        y_sat;
  logic signed [AW-1:0]       acc;
  logic                       rdy_q;
  logic                       vld_q;

  // Recursion runs with G_FRAC_BITS of guard below the sample LSB so the
  // pole leak does not stall at integer granularity.
  always_comb begin
    x_ext = {din_q, {G_FRAC_BITS{1'b0}}};
    acc   = AW'(x_ext) - AW'(x1) + AW'(y1) - AW'(y1 >>> G_POLE_SHIFT);
    if (acc > ACC_MAX) begin
      y_sat = Y_MAX;
    end else if (acc < ACC_MIN) begin
      y_sat = Y_MIN;
    end else begin
      y_sat = acc[W-1:0];
    end
  end

  assign s.din_ready  = bypass ? s.dout_ready : rdy_q;
  assign s.dout_valid = bypass ? s.din_valid  : vld_q;
  assign s.dout       = bypass ? s.din        : dout_q;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state  <= SM_INIT;
      din_q  <= '0;
      dout_q <= '0;
      x1     <= '0;
      y1     <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      if (bypass) begin
        // Any in-flight sample is dropped; history stays as it was.
        state <= SM_GET_INPUT;
        rdy_q <= 1'b1;
        vld_q <= 1'b0;
      end else begin
        case (state)
          SM_INIT: begin
            state <= SM_GET_INPUT;
            rdy_q <= 1'b1;
          end
          SM_GET_INPUT: begin
            if (s.din_valid && rdy_q) begin
              din_q <= s.din;
              rdy_q <= 1'b0;
              state <= SM_COMPUTE;
            end
          end
          SM_COMPUTE: begin
            x1     <= x_ext;
            y1     <= y_sat;
            dout_q <= y_sat[W-1:G_FRAC_BITS];
            vld_q  <= 1'b1;
            state  <= SM_SEND_OUTPUT;
          end
          SM_SEND_OUTPUT: begin
            if (s.dout_ready) begin
              vld_q <= 1'b0;
              rdy_q <= 1'b1;
              state <= SM_GET_INPUT;
            end
          end
          default: begin
            state <= SM_INIT;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
          end
        endcase
      end
      // Flush overrides a same-cycle commit; the commit itself used old history.
      if (flush) begin
        x1 <= '0;
        y1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dc_blocking_filter.sv
// tb/tb_dc_blocking_filter.sv - directed self-checking bench for dc_blocking_filter
module tb_dc_blocking_filter;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b1;
  logic bypass = 1'b0;
  logic flush  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  dc_blocking_filter_if #(.G_DWIDTH(24)) intf ();

  dc_blocking_filter #(
    .G_DWIDTH    (24),
    .G_POLE_SHIFT(10),
    .G_FRAC_BITS (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .bypass(bypass),
    .flush (flush),
    .s     (intf.slave)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    bypass = 1'b0;
    flush = 1'b0;
    intf.din_valid = 1'b0;
    intf.dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One full transaction; lat counts sampled cycles from acceptance to dout_valid.
  task automatic do_xfer(input logic signed [23:0] v, output logic signed [23:0] got,
                         output int lat, output bit ok);
    int n;
    ok = 1'b1;
    got = '0;
    lat = 0;
    intf.din = v;
    intf.din_valid = 1'b1;
    intf.dout_ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (intf.din_ready) break;
      n++;
      if (n > 20) begin ok = 1'b0; break; end
    end
    @(posedge clk);
    #1 intf.din_valid = 1'b0;
    if (ok) begin
      forever begin
        @(negedge clk);
        lat++;
        if (intf.dout_valid) break;
        if (lat > 10) begin ok = 1'b0; break; end
      end
      got = intf.dout;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    intf.din_valid = 1'b0;
    intf.dout_ready = 1'b1;
    intf.din = 24'sd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (intf.dout !== 24'sd0) begin n_fail++; $display("FAIL reset_dout: got %0d want 0", intf.dout); end
    n_checks++;
    if (intf.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b want 0", intf.dout_valid); end
    n_checks++;
    if (intf.din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %b want 0", intf.din_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (intf.din_ready !== 1'b1) begin n_fail++; $display("FAIL release_din_ready: got %b want 1", intf.din_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_step();
    logic signed [23:0] got, prev;
    int lat, mono_bad, neg_bad, lat_bad;
    bit ok, all_ok;
    do_reset();
    prev = 24'sd1000;
    mono_bad = 0; neg_bad = 0; lat_bad = 0; all_ok = 1'b1;
    got = '0;
    for (int i = 0; i < 20000; i++) begin
      do_xfer(24'sd1000, got, lat, ok);
      if (!ok) begin all_ok = 1'b0; break; end
      if (i == 0) begin
        n_checks++;
        if (got !== 24'sd1000) begin n_fail++; $display("FAIL step_out0: got %0d want 1000", got); end
      end
      if (i == 1) begin
        n_checks++;
        if (got !== 24'sd999) begin n_fail++; $display("FAIL step_out1: got %0d want 999", got); end
      end
      if (i == 2) begin
        n_checks++;
        if (got !== 24'sd998) begin n_fail++; $display("FAIL step_out2: got %0d want 998", got); end
      end
      if (lat != 2) lat_bad++;
      if (got > prev) mono_bad++;
      if (got < 0) neg_bad++;
      prev = got;
    end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL step_timeout: got timeout want handshake"); end
    n_checks++;
    if (lat_bad != 0) begin n_fail++; $display("FAIL step_latency: got %0d bad samples want 0", lat_bad); end
    n_checks++;
    if (mono_bad != 0) begin n_fail++; $display("FAIL step_monotonic: got %0d increases want 0", mono_bad); end
    n_checks++;
    if (neg_bad != 0) begin n_fail++; $display("FAIL step_negative: got %0d negatives want 0", neg_bad); end
    n_checks++;
    if (got < 0 || got > 3) begin n_fail++; $display("FAIL step_settled: got %0d want 0..3", got); end
  endtask

  task automatic test_saturation();
    logic signed [23:0] got;
    int lat;
    bit ok;
    do_reset();
    do_xfer(24'sd8388607, got, lat, ok);
    n_checks++;
    if (!ok || got !== 24'sd8388607) begin n_fail++; $display("FAIL sat_pos: got %0d want 8388607", got); end
    do_xfer(-24'sd8388608, got, lat, ok);
    n_checks++;
    if (!ok || got !== -24'sd8388608) begin n_fail++; $display("FAIL sat_neg: got %0d want -8388608", got); end
    do_xfer(24'sd8388607, got, lat, ok);
    n_checks++;
    if (!ok || got !== 24'sd8388607) begin n_fail++; $display("FAIL sat_pos_again: got %0d want 8388607", got); end
  endtask

  task automatic test_backpressure();
    logic signed [23:0] held;
    int n, hs;
    do_reset();
    intf.dout_ready = 1'b0;
    intf.din = 24'sd1234;
    intf.din_valid = 1'b1;
    n = 0;
    while (!intf.dout_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = intf.dout;
    n_checks++;
    if (intf.dout_valid !== 1'b1 || held !== 24'sd1234) begin
      n_fail++; $display("FAIL bp_first: got valid=%b dout=%0d want valid=1 dout=1234", intf.dout_valid, held);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (intf.dout !== held || intf.dout_valid !== 1'b1 || intf.din_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got dout=%0d valid=%b ready=%b want dout=1234 valid=1 ready=0",
                 k, intf.dout, intf.dout_valid, intf.din_ready);
      end
    end
    intf.dout_ready = 1'b1;
    intf.din_valid = 1'b0;
    hs = 0;
    for (int k = 0; k < 3; k++) begin
      if (intf.dout_valid && intf.dout_ready) hs++;
      @(negedge clk);
    end
    n_checks++;
    if (hs != 1) begin n_fail++; $display("FAIL bp_handshakes: got %0d want 1", hs); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass_flush(input bit use_flush, input logic signed [23:0] want);
    logic signed [23:0] got;
    int lat;
    bit ok;
    do_reset();
    do_xfer(24'sd1000, got, lat, ok);
    do_xfer(24'sd1000, got, lat, ok);
    n_checks++;
    if (!ok || got !== 24'sd999) begin n_fail++; $display("FAIL bypass_pre: got %0d want 999", got); end
    bypass = 1'b1;
    for (int k = 0; k < 5; k++) begin
      intf.din = 24'sd0;
      intf.din_valid = 1'b1;
      intf.dout_ready = (k % 2 == 0);
      #1;
      n_checks++;
      if (intf.dout !== 24'sd0 || intf.dout_valid !== 1'b1 || intf.din_ready !== (k % 2 == 0)) begin
        n_fail++;
        $display("FAIL bypass_pass%0d: got dout=%0d valid=%b ready=%b want dout=0 valid=1 ready=%0d",
                 k, intf.dout, intf.dout_valid, intf.din_ready, (k % 2 == 0));
      end
      @(posedge clk);
      #1;
    end
    intf.din_valid = 1'b0;
    intf.dout_ready = 1'b1;
    if (use_flush) begin
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
    end
    bypass = 1'b0;
    @(posedge clk);
    #1;
    do_xfer(24'sd1000, got, lat, ok);
    n_checks++;
    if (!ok || got !== want) begin
      n_fail++; $display("FAIL bypass_resume(flush=%0d): got %0d want %0d", use_flush, got, want);
    end
  endtask

  initial begin
    intf.din = 24'sd0;
    intf.din_valid = 1'b0;
    intf.dout_ready = 1'b1;
    test_reset();
    test_step();
    test_saturation();
    test_backpressure();
    test_bypass_flush(1'b0, 24'sd998);
    test_bypass_flush(1'b1, 24'sd1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
